// File: rtl/d_cache_tag_ctrl.sv
// d_cache_tag_ctrl: direct-mapped data cache tag controller.
// Sequences tag RAM lookup, hit/miss response, line refill handshake and
// tag write-back. Optional macro DCACHE_FLUSH_EN adds the invalidate-all
// FLUSH state, flush_i handling and an automatic tag RAM clear after reset.
module d_cache_tag_ctrl #(
    parameter int unsigned TAG_W = 55,
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [63:0]      req_addr_i,
    output logic             resp_valid_o,
    output logic             hit_o,
    output logic             miss_o,
    output logic             refill_req_o,
    output logic [63:0]      refill_addr_o,
    input  logic             refill_done_i,
    input  logic             flush_i,
    output logic             flush_busy_o,
    output logic [IDX_W-1:0] tag_addr_o,
    output logic [TAG_W:0]   tag_data_o,
    output logic             tag_we_o,
    input  logic [TAG_W-1:0] tag_data_i,
    input  logic             tag_valid_i
);

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned LINE_W = ADDR_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        REFILL,
        TAG_WRITE
`ifdef DCACHE_FLUSH_EN
        , FLUSH
`endif
    } state_t;

    state_t              state;
    logic [LINE_W-1:0]   line_q;
    logic                tag_match_c;
    logic                ready_idle_c;
    logic                unused_c;

    // Line address of the in-flight request: tag in the top bits, set index in the bottom bits.
    assign tag_match_c = tag_valid_i && (tag_data_i == line_q[LINE_W-1 -: TAG_W]);

`ifdef DCACHE_FLUSH_EN
    logic             pend_q;
    logic             init_q;
    logic [IDX_W-1:0] cnt_q;
    logic             pend_nxt_c;

    // A flush seen while busy is remembered and blocks new requests on return to IDLE.
    assign pend_nxt_c   = pend_q | flush_i;
    assign ready_idle_c = ~pend_nxt_c;
    assign unused_c     = ^req_addr_i[OFF_W-1:0];
`else
    assign ready_idle_c = 1'b1;
    assign flush_busy_o = 1'b0;
    assign unused_c     = ^{req_addr_i[OFF_W-1:0], flush_i};
`endif

    // Controller state machine; every output is registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            line_q        <= '0;
            resp_valid_o  <= 1'b0;
            hit_o         <= 1'b0;
            miss_o        <= 1'b0;
            refill_req_o  <= 1'b0;
            refill_addr_o <= '0;
            tag_addr_o    <= '0;
            tag_data_o    <= '0;
            tag_we_o      <= 1'b0;
`ifdef DCACHE_FLUSH_EN
            req_ready_o   <= 1'b0;
            flush_busy_o  <= 1'b0;
            pend_q        <= 1'b0;
            init_q        <= 1'b1;
            cnt_q         <= '0;
`else
            req_ready_o   <= 1'b1;
`endif
        end else begin
            resp_valid_o <= 1'b0;
            hit_o        <= 1'b0;
            miss_o       <= 1'b0;
            tag_we_o     <= 1'b0;
            tag_data_o   <= '0;
`ifdef DCACHE_FLUSH_EN
            if (state != IDLE) begin
                pend_q <= pend_nxt_c;
            end
`endif
            case (state)
                IDLE: begin
`ifdef DCACHE_FLUSH_EN
                    if (flush_i || pend_q || init_q) begin
                        state        <= FLUSH;
                        pend_q       <= 1'b0;
                        init_q       <= 1'b0;
                        cnt_q        <= '0;
                        tag_addr_o   <= '0;
                        tag_we_o     <= 1'b1;
                        flush_busy_o <= 1'b1;
                        req_ready_o  <= 1'b0;
                    end else
`endif
                    if (req_valid_i && req_ready_o) begin
                        state       <= LOOKUP;
                        line_q      <= req_addr_i[ADDR_W-1:OFF_W];
                        tag_addr_o  <= req_addr_i[OFF_W +: IDX_W];
                        req_ready_o <= 1'b0;
                    end
                end
                LOOKUP: begin
                    state <= COMPARE;
                end
                COMPARE: begin
                    if (tag_match_c) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b1;
                        hit_o        <= 1'b1;
                        req_ready_o  <= ready_idle_c;
                    end else begin
                        state         <= REFILL;
                        refill_req_o  <= 1'b1;
                        refill_addr_o <= {line_q, 3'b000};
                    end
                end
                REFILL: begin
                    if (refill_done_i) begin
                        state         <= TAG_WRITE;
                        refill_req_o  <= 1'b0;
                        refill_addr_o <= '0;
                        tag_we_o      <= 1'b1;
                        tag_addr_o    <= line_q[IDX_W-1:0];
                        tag_data_o    <= {1'b1, line_q[LINE_W-1 -: TAG_W]};
                        resp_valid_o  <= 1'b1;
                        miss_o        <= 1'b1;
                    end
                end
                TAG_WRITE: begin
                    state       <= IDLE;
                    req_ready_o <= ready_idle_c;
                end
`ifdef DCACHE_FLUSH_EN
                FLUSH: begin
                    cnt_q <= cnt_q + IDX_W'(1);
                    if (cnt_q == '1) begin
                        state        <= IDLE;
                        flush_busy_o <= 1'b0;
                        req_ready_o  <= ready_idle_c;
                    end else begin
                        tag_we_o   <= 1'b1;
                        tag_addr_o <= cnt_q + IDX_W'(1);
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_cache_tag_ctrl.sv
// Self-checking bench for d_cache_tag_ctrl: table vectors, hand-written
// corner sequences and random lookups against a set-level cache model.
// Honours DCACHE_FLUSH_EN the same way as the design.
module tb_d_cache_tag_ctrl;

    localparam int unsigned TAG_W = 55;
    localparam int unsigned IDX_W = 6;
`ifdef DCACHE_FLUSH_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic [63:0]      req_addr_i = '0;
    logic             resp_valid_o;
    logic             hit_o;
    logic             miss_o;
    logic             refill_req_o;
    logic [63:0]      refill_addr_o;
    logic             refill_done_i = 1'b0;
    logic             flush_i = 1'b0;
    logic             flush_busy_o;
    logic [IDX_W-1:0] tag_addr_o;
    logic [TAG_W:0]   tag_data_o;
    logic             tag_we_o;
    logic [TAG_W-1:0] tag_data_i = '0;
    logic             tag_valid_i = 1'b0;

    int n_asrt = 0;
    int n_fail = 0;

    d_cache_tag_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .resp_valid_o(resp_valid_o), .hit_o(hit_o), .miss_o(miss_o),
        .refill_req_o(refill_req_o), .refill_addr_o(refill_addr_o), .refill_done_i(refill_done_i),
        .flush_i(flush_i), .flush_busy_o(flush_busy_o),
        .tag_addr_o(tag_addr_o), .tag_data_o(tag_data_o), .tag_we_o(tag_we_o),
        .tag_data_i(tag_data_i), .tag_valid_i(tag_valid_i)
    );

    always #5 clk = ~clk;

    // Tag RAM: registered read, write when tag_we_o is high, starts cleared.
    logic [TAG_W:0] ram [64];
    initial for (int i = 0; i < 64; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (tag_we_o) ram[tag_addr_o] <= tag_data_o;
        else {tag_valid_i, tag_data_i} <= ram[tag_addr_o];
    end

    // Reference: which line tag each set currently holds.
    logic [TAG_W:0] ref_tags [64];
    initial for (int i = 0; i < 64; i++) ref_tags[i] = '0;

    function automatic logic predict(input logic [63:0] a);
        logic [TAG_W:0] e;
        e = ref_tags[a[8:3]];
        return e[TAG_W] && (e[TAG_W-1:0] == a[63:9]);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response qualification must hold on every cycle out of reset.
    always @(negedge clk) begin
        if (rst) begin
            chk("hit_miss_exclusive", 128'(hit_o && miss_o), 128'(0));
            chk("unqualified_result", 128'(!resp_valid_o && (hit_o || miss_o)), 128'(0));
        end
    end

    // One lookup from ready-wait to the first idle cycle after the response.
    task automatic do_req(input logic [63:0] addr, input int dly, input logic exp_hit, input bit fl);
        logic [TAG_W-1:0] tag;
        logic [5:0]       idx;
        int               w;
        tag = addr[63:9];
        idx = addr[8:3];
        w = 0;
        while (req_ready_o !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_req", 128'(req_ready_o), 128'(1));
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("lookup_ready_low", 128'(req_ready_o), 128'(0));
        chk("lookup_no_resp", 128'(resp_valid_o), 128'(0));
        chk("lookup_tag_addr", 128'(tag_addr_o), 128'(idx));
        chk("lookup_tag_we", 128'(tag_we_o), 128'(0));
        @(negedge clk);
        chk("compare_no_resp", 128'(resp_valid_o), 128'(0));
        @(negedge clk);
        if (exp_hit) begin
            chk("hit_resp_valid", 128'(resp_valid_o), 128'(1));
            chk("hit_hit", 128'(hit_o), 128'(1));
            chk("hit_miss", 128'(miss_o), 128'(0));
            chk("hit_no_refill", 128'(refill_req_o), 128'(0));
        end else begin
            chk("miss_refill_req", 128'(refill_req_o), 128'(1));
            chk("miss_refill_addr", 128'(refill_addr_o), 128'({addr[63:3], 3'b000}));
            chk("miss_no_early_resp", 128'(resp_valid_o), 128'(0));
            flush_i = fl;
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                flush_i = 1'b0;
                chk("stall_refill_req", 128'(refill_req_o), 128'(1));
                chk("stall_ready_low", 128'(req_ready_o), 128'(0));
                chk("stall_no_resp", 128'(resp_valid_o), 128'(0));
            end
            refill_done_i = 1'b1;
            @(negedge clk);
            refill_done_i = 1'b0;
            flush_i = 1'b0;
            chk("tw_we", 128'(tag_we_o), 128'(1));
            chk("tw_addr", 128'(tag_addr_o), 128'(idx));
            chk("tw_data", 128'(tag_data_o), 128'({1'b1, tag}));
            chk("tw_resp_valid", 128'(resp_valid_o), 128'(1));
            chk("tw_miss", 128'(miss_o), 128'(1));
            chk("tw_hit", 128'(hit_o), 128'(0));
            chk("tw_refill_dropped", 128'(refill_req_o), 128'(0));
            ref_tags[idx] = {1'b1, tag};
        end
        @(negedge clk);
        chk("post_resp_clear", 128'(resp_valid_o), 128'(0));
        chk("post_ready", 128'(req_ready_o), 128'(!(fl && FE && !exp_hit)));
    endtask

`ifdef DCACHE_FLUSH_EN
    // Follow one complete invalidate-all sweep of the tag RAM.
    task automatic watch_flush();
        int w;
        w = 0;
        while (flush_busy_o !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("flush_start", 128'(flush_busy_o), 128'(1));
        for (int i = 0; i < 64; i++) begin
            chk("flush_busy", 128'(flush_busy_o), 128'(1));
            chk("flush_we", 128'(tag_we_o), 128'(1));
            chk("flush_addr", 128'(tag_addr_o), 128'(i));
            chk("flush_data", 128'(tag_data_o), 128'(0));
            chk("flush_ready_low", 128'(req_ready_o), 128'(0));
            @(negedge clk);
        end
        chk("flush_end_busy", 128'(flush_busy_o), 128'(0));
        chk("flush_end_we", 128'(tag_we_o), 128'(0));
        chk("flush_end_ready", 128'(req_ready_o), 128'(1));
        for (int i = 0; i < 64; i++) ref_tags[i] = '0;
    endtask
`endif

    typedef struct {
        logic [63:0] addr;
        int          dly;
        logic        exp_hit;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [63:0] a;
        logic        ph;
        bit          fl;

        vecs[0] = '{64'h0000_0000_8000_0208, 3,  1'b0};
        vecs[1] = '{64'h0000_0000_8000_0208, 0,  1'b1};
        vecs[2] = '{64'h0000_0000_8000_0408, 20, 1'b0};
        vecs[3] = '{64'h0000_0000_8000_0208, 1,  1'b0};
        vecs[4] = '{64'h0000_0000_8000_0208, 0,  1'b1};
        vecs[5] = '{64'h0000_0000_8000_0408, 0,  1'b0};
        vecs[6] = '{64'h0000_0000_8000_020C, 2,  1'b0};
        vecs[7] = '{64'h0000_0000_8000_0208, 0,  1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(req_ready_o), 128'(!FE));
        chk("rst_resp", 128'(resp_valid_o), 128'(0));
        chk("rst_refill", 128'(refill_req_o), 128'(0));
        chk("rst_refill_addr", 128'(refill_addr_o), 128'(0));
        chk("rst_we", 128'(tag_we_o), 128'(0));
        chk("rst_busy", 128'(flush_busy_o), 128'(0));
        rst = 1'b1;
`ifdef DCACHE_FLUSH_EN
        watch_flush();
`else
        @(negedge clk);
        chk("boot_ready", 128'(req_ready_o), 128'(1));
`endif

        // Table vectors: fill, hit, conflict, stall, re-miss
        for (int v = 0; v < 8; v++) begin
            do_req(vecs[v].addr, vecs[v].dly, vecs[v].exp_hit, 1'b0);
        end

        // Stray refill_done in IDLE changes nothing
        refill_done_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stray_done_we", 128'(tag_we_o), 128'(0));
            chk("stray_done_resp", 128'(resp_valid_o), 128'(0));
            chk("stray_done_ready", 128'(req_ready_o), 128'(1));
        end
        refill_done_i = 1'b0;
        do_req(64'h0000_0000_8000_0208, 0, predict(64'h0000_0000_8000_0208), 1'b0);

`ifdef DCACHE_FLUSH_EN
        // Flush raised during a refill runs after the miss completes
        a = 64'h0000_0000_8000_0608;
        do_req(a, 4, predict(a), 1'b1);
        chk("pending_no_busy_yet", 128'(flush_busy_o), 128'(0));
        watch_flush();
        do_req(a, 0, 1'b0, 1'b0);

        // Flush wins over a simultaneous request, which is taken right after
        a = 64'h0000_0000_8000_0608;
        @(negedge clk);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        @(negedge clk);
        flush_i = 1'b0;
        chk("prio_busy", 128'(flush_busy_o), 128'(1));
        chk("prio_tag_addr", 128'(tag_addr_o), 128'(0));
        watch_flush();
        do_req(a, 1, 1'b0, 1'b0);
`else
        // flush_i has no effect without the flush feature
        flush_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("noflush_busy", 128'(flush_busy_o), 128'(0));
            chk("noflush_we", 128'(tag_we_o), 128'(0));
            chk("noflush_ready", 128'(req_ready_o), 128'(1));
        end
        flush_i = 1'b0;
        do_req(64'h0000_0000_8000_0208, 0, 1'b1, 1'b0);
`endif

        // Asynchronous reset while a refill is outstanding
        a = 64'h1234_5678_0000_0040;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_refill", 128'(refill_req_o), 128'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("async_refill_drop", 128'(refill_req_o), 128'(0));
        chk("async_no_resp", 128'(resp_valid_o), 128'(0));
        chk("async_ready", 128'(req_ready_o), 128'(!FE));
        @(negedge clk);
        chk("rst_hold_no_resp", 128'(resp_valid_o), 128'(0));
        rst = 1'b1;
`ifdef DCACHE_FLUSH_EN
        watch_flush();
`else
        @(negedge clk);
        chk("rerst_ready", 128'(req_ready_o), 128'(1));
        chk("rerst_no_resp", 128'(resp_valid_o), 128'(0));
`endif
        do_req(a, 0, predict(a), 1'b0);

        // Random lookups over a few sets and tags to mix hits and conflicts
        for (int n = 0; n < 40; n++) begin
            a  = {9'h0, 55'h40_0000 + 55'($urandom_range(0, 2)), 3'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7))};
            a  = {a[63:9] >> 0, a[8:0]};
            a[63:9] = 55'h40_0000 + 55'($urandom_range(0, 2));
            a[8:3]  = 6'($urandom_range(0, 3));
            a[2:0]  = 3'($urandom_range(0, 7));
            ph = predict(a);
            fl = FE && !ph && ($urandom_range(0, 7) == 0);
            do_req(a, int'($urandom_range(0, 5)), ph, fl);
`ifdef DCACHE_FLUSH_EN
            if (fl) watch_flush();
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
